// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: FSM encoding and the
// opcode/ALU field values that define a mul/div instruction in D/X.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; used for the stall-cycle debug count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use, X redirect and mul/div handshake into
// pipeline write enables. Optional watchdog: define PIPELINE_CTRL_WATCHDOG_EN.
//
// state   | meaning
// RUN     | normal flow; redirect/load-use handled, mul/div in D/X issues md_start
// MD_WAIT | pipeline frozen until md_ready (or watchdog abort)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_use_hazard,
  input  logic             dx_is_md,
  input  logic             md_ready,
  input  logic             x_redirect,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_abort,
  output logic [CNT_W-1:0] stall_count
);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       out_of_reset;
  logic       wd_expired;
  logic       stall_en;

  // Holds off md_start until the first clock edge after reset is released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef PIPELINE_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(MD_TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == RUN) begin
      wd_cnt <= '0;
    end else if (!md_ready && !wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expired = (state == MD_WAIT) && (wd_cnt == WD_W'(MD_TIMEOUT));
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = (MD_TIMEOUT > 0);
  assign wd_expired    = 1'b0;
`endif

  always_comb begin
    pc_we     = 1'b1;
    fd_we     = 1'b1;
    dx_we     = 1'b1;
    fd_flush  = 1'b0;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    md_start  = 1'b0;
    md_abort  = 1'b0;
    state_nxt = state;
    case (state)
      MD_WAIT: begin
        if (md_ready) begin
          state_nxt = RUN;
        end else if (wd_expired) begin
          // Pipeline released but the mul/div result is dropped.
          md_abort  = 1'b1;
          xm_bubble = 1'b1;
          state_nxt = RUN;
        end else begin
          pc_we     = 1'b0;
          fd_we     = 1'b0;
          dx_we     = 1'b0;
          xm_bubble = 1'b1;
        end
      end
      default: begin
        if (dx_is_md) begin
          pc_we     = 1'b0;
          fd_we     = 1'b0;
          dx_we     = 1'b0;
          xm_bubble = 1'b1;
          md_start  = out_of_reset;
          if (out_of_reset) begin
            state_nxt = MD_WAIT;
          end
        end else if (x_redirect) begin
          fd_flush  = 1'b1;
          dx_bubble = 1'b1;
        end else if (load_use_hazard) begin
          pc_we     = 1'b0;
          fd_we     = 1'b0;
          dx_bubble = 1'b1;
        end
      end
    endcase
  end

  assign md_busy  = (state == MD_WAIT);
  assign stall_en = ~pc_we;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (stall_en),
    .count   (stall_count)
  );

endmodule
